// File: rtl/centroid_divider_if.sv
// Handshake and data bundle between the gravity-sum stage and the centroid divider.
interface centroid_divider_if #(
  parameter int SUM_S_WIDTH   = 20,
  parameter int SUM_SXY_WIDTH = 28,
  parameter int FRAC_BITS     = 4,
  parameter int COORD_WIDTH   = 10
);
  logic                               iSTART_TRIG;
  logic [SUM_S_WIDTH-1:0]             iSUM_S;
  logic [SUM_SXY_WIDTH-1:0]           iSUM_SX;
  logic [SUM_SXY_WIDTH-1:0]           iSUM_SY;
  logic                               oBUSY;
  logic [COORD_WIDTH+FRAC_BITS-1:0]   oCX;
  logic [COORD_WIDTH+FRAC_BITS-1:0]   oCY;
  logic                               oVALID;
  logic                               oNO_TARGET;
  logic [1:0]                         oSTATE;

  modport master (
    output iSTART_TRIG, iSUM_S, iSUM_SX, iSUM_SY,
    input  oBUSY, oCX, oCY, oVALID, oNO_TARGET, oSTATE
  );

  modport slave (
    input  iSTART_TRIG, iSUM_S, iSUM_SX, iSUM_SY,
    output oBUSY, oCX, oCY, oVALID, oNO_TARGET, oSTATE
  );
endinterface

// File: rtl/centroid_divider.sv
// Centroid divider: two sequential restoring divisions (sum_sx/sum_s, sum_sy/sum_s)
// started by the falling edge of iSTART_TRIG, results in unsigned fixed point.
module centroid_divider #(
  parameter int SUM_S_WIDTH   = 20,
  parameter int SUM_SXY_WIDTH = 28,
  parameter int FRAC_BITS     = 4,
  parameter int COORD_WIDTH   = 10
) (
  input  logic              CCLK,
  input  logic              RST_N,
  centroid_divider_if.slave bus
);
  localparam int N  = SUM_SXY_WIDTH + FRAC_BITS;
  localparam int OW = COORD_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV_X = 2'd1, DIV_Y = 2'd2, DONE = 2'd3} state_t;

  state_t                   state, state_nx;
  logic                     trig_d;
  logic                     start_ev;
  logic [SUM_S_WIDTH-1:0]   sum_s;
  logic [SUM_SXY_WIDTH-1:0] sum_sx, sum_sy;
  logic [SUM_S_WIDTH-1:0]   rem;
  logic [N-1:0]             quo;
  logic [CW-1:0]            cnt;
  logic [OW-1:0]            qx, qy;
  logic                     busy_q, valid_q, no_tgt_q;
  logic [OW-1:0]            cx_q, cy_q;

  logic                     do_load, do_step, last_step, do_exit;
  logic [SUM_S_WIDTH:0]     rem_sh;
  logic [SUM_S_WIDTH-1:0]   rem_diff, rem_nx;
  logic                     q_bit;
  logic [N-1:0]             quo_nx;
  logic [OW-1:0]            quo_sat;

  assign start_ev = trig_d & ~bus.iSTART_TRIG;

  // quo doubles as the dividend shift register: the dividend drains out of the
  // top while quotient bits enter at the bottom.
  always_comb begin
    rem_sh   = {rem, quo[N-1]};
    q_bit    = (rem_sh >= {1'b0, sum_s});
    rem_diff = rem_sh[SUM_S_WIDTH-1:0] - sum_s;
    rem_nx   = q_bit ? rem_diff : rem_sh[SUM_S_WIDTH-1:0];
    quo_nx   = {quo[N-2:0], q_bit};
    quo_sat  = (quo_nx[N-1:OW] != '0) ? '1 : quo_nx[OW-1:0];
  end

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start_ev) state_nx = (bus.iSUM_S != '0) ? DIV_X : DONE;
      DIV_X: if (cnt == CW'(N-1)) state_nx = DIV_Y;
      DIV_Y: if (cnt == CW'(N-1)) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    do_load   = (state == IDLE) && start_ev;
    do_step   = (state == DIV_X) || (state == DIV_Y);
    last_step = do_step && (cnt == CW'(N-1));
    do_exit   = (state == DONE);
  end

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      trig_d   <= 1'b0;
      sum_s    <= '0;
      sum_sx   <= '0;
      sum_sy   <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      qx       <= '0;
      qy       <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      no_tgt_q <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
    end else begin
      trig_d  <= bus.iSTART_TRIG;
      valid_q <= 1'b0;
      if (do_load) begin
        sum_s  <= bus.iSUM_S;
        sum_sx <= bus.iSUM_SX;
        sum_sy <= bus.iSUM_SY;
        rem    <= '0;
        quo    <= {bus.iSUM_SX, {FRAC_BITS{1'b0}}};
        cnt    <= '0;
        qx     <= '0;
        qy     <= '0;
        busy_q <= 1'b1;
      end
      if (do_step) begin
        if (last_step) begin
          cnt <= '0;
          rem <= '0;
          if (state == DIV_X) begin
            qx  <= quo_sat;
            quo <= {sum_sy, {FRAC_BITS{1'b0}}};
          end else begin
            qy  <= quo_sat;
            quo <= quo_nx;
          end
        end else begin
          cnt <= cnt + CW'(1);
          rem <= rem_nx;
          quo <= quo_nx;
        end
      end
      if (do_exit) begin
        cx_q     <= qx;
        cy_q     <= qy;
        no_tgt_q <= (sum_s == '0);
        valid_q  <= 1'b1;
        busy_q   <= 1'b0;
      end
    end
  end

  assign bus.oBUSY      = busy_q;
  assign bus.oVALID     = valid_q;
  assign bus.oCX        = cx_q;
  assign bus.oCY        = cy_q;
  assign bus.oNO_TARGET = no_tgt_q;
  assign bus.oSTATE     = state;
endmodule

// File: tb/tb_centroid_divider.sv
// Scoreboard bench for centroid_divider: stimulus pushes model results, a negedge monitor checks them.
module tb_centroid_divider;
  logic clk;
  logic rst_n;

  centroid_divider_if #(.SUM_S_WIDTH(20), .SUM_SXY_WIDTH(28), .FRAC_BITS(4), .COORD_WIDTH(10)) bus ();

  centroid_divider #(
    .SUM_S_WIDTH(20), .SUM_SXY_WIDTH(28), .FRAC_BITS(4), .COORD_WIDTH(10)
  ) dut (
    .CCLK(clk),
    .RST_N(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] cx;
    logic [13:0] cy;
    logic        nt;
    int          blen;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_valid = 0;
  int   busy_run = 0;
  logic [13:0] last_cx = '0, last_cy = '0;
  logic        last_nt = 1'b0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Fixed-point centroid from plain arithmetic: floor(sum*16/s), clamped to 14 bits.
  function automatic logic [13:0] ref_coord(input longint unsigned s, input longint unsigned sum);
    longint unsigned q;
    if (s == 0) return 14'd0;
    q = (sum * 16) / s;
    if (q > 16383) return 14'h3FFF;
    return q[13:0];
  endfunction

  function automatic exp_t make_exp(input longint unsigned s, input longint unsigned sx,
                                    input longint unsigned sy);
    exp_t e;
    e.cx   = ref_coord(s, sx);
    e.cy   = ref_coord(s, sy);
    e.nt   = (s == 0);
    e.blen = (s == 0) ? 1 : 65;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
      last_cx  = '0;
      last_cy  = '0;
      last_nt  = 1'b0;
    end else begin
      if (bus.oVALID) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got oVALID=1 expected no pulse");
          last_cx = bus.oCX;
          last_cy = bus.oCY;
          last_nt = bus.oNO_TARGET;
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("cx", bus.oCX, e.cx);
          chk("cy", bus.oCY, e.cy);
          chk("no_target", bus.oNO_TARGET, e.nt);
          chk("busy_len", busy_run, e.blen);
          last_cx = e.cx;
          last_cy = e.cy;
          last_nt = e.nt;
        end
        busy_run = 0;
      end else begin
        chk("hold_cx", bus.oCX, last_cx);
        chk("hold_cy", bus.oCY, last_cy);
        chk("hold_nt", bus.oNO_TARGET, last_nt);
      end
      if (bus.oBUSY) busy_run++;
    end
  end

  task automatic wait_valid(input int target);
    int n;
    n = 0;
    while (n_valid < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("valid_seen", (n_valid >= target), 1);
  endtask

  task automatic run_op(input logic [19:0] s, input logic [27:0] sx, input logic [27:0] sy,
                        input int hi_cycles);
    int base;
    base = n_valid;
    @(posedge clk); #1;
    bus.iSUM_S      = s;
    bus.iSUM_SX     = sx;
    bus.iSUM_SY     = sy;
    bus.iSTART_TRIG = 1'b1;
    repeat (hi_cycles) @(posedge clk);
    #1;
    exp_q.push_back(make_exp(s, sx, sy));
    bus.iSTART_TRIG = 1'b0;
    wait_valid(base + 1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int base;
    logic [19:0] rs;
    bus.iSTART_TRIG = 1'b0;
    bus.iSUM_S      = '0;
    bus.iSUM_SX     = '0;
    bus.iSUM_SY     = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.oBUSY, 0);
    chk("rst_valid", bus.oVALID, 0);
    chk("rst_cx", bus.oCX, 0);
    chk("rst_state", bus.oSTATE, 0);
    rst_n = 1'b1;

    // Trigger held low after reset must not start anything.
    repeat (10) @(posedge clk);
    #1;
    chk("idle_busy", bus.oBUSY, 0);
    chk("idle_nvalid", n_valid, 0);

    // Nominal case with a long trigger high phase; also look at state right after E0.
    @(posedge clk); #1;
    bus.iSUM_S = 20'd100; bus.iSUM_SX = 28'd32000; bus.iSUM_SY = 28'd24050;
    bus.iSTART_TRIG = 1'b1;
    repeat (512) @(posedge clk);
    #1;
    exp_q.push_back(make_exp(100, 32000, 24050));
    bus.iSTART_TRIG = 1'b0;
    @(posedge clk); #1;
    chk("state_div_x", bus.oSTATE, 1);
    chk("busy_rise", bus.oBUSY, 1);
    wait_valid(1);
    repeat (2) @(posedge clk);

    run_op(20'd3, 28'd10, 28'd0, 1);
    run_op(20'd1, 28'd2000, 28'd5, 2);
    run_op(20'd0, 28'd12345, 28'd999, 3);

    // A second trigger during DIV_Y is ignored, then a later one is honoured.
    base = n_valid;
    @(posedge clk); #1;
    bus.iSUM_S = 20'd100; bus.iSUM_SX = 28'd32000; bus.iSUM_SY = 28'd24050;
    bus.iSTART_TRIG = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(make_exp(100, 32000, 24050));
    bus.iSTART_TRIG = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    chk("in_div_y", bus.oSTATE, 2);
    bus.iSUM_S = 20'd7; bus.iSUM_SX = 28'd1234; bus.iSUM_SY = 28'd567;
    bus.iSTART_TRIG = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.iSTART_TRIG = 1'b0;
    wait_valid(base + 1);
    repeat (80) @(posedge clk);
    #1;
    chk("single_valid", n_valid, base + 1);
    run_op(20'd7, 28'd1234, 28'd567, 2);

    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0:       rs = 20'd0;
        1:       rs = 20'($urandom_range(1, 15));
        2:       rs = 20'($urandom_range(1, 1000));
        default: rs = 20'($urandom);
      endcase
      run_op(rs, 28'($urandom), 28'($urandom), int'($urandom_range(1, 5)));
    end

    // Reset during DIV_X clears outputs at once and no result follows.
    @(posedge clk); #1;
    bus.iSUM_S = 20'd50; bus.iSUM_SX = 28'd40000; bus.iSUM_SY = 28'd30000;
    bus.iSTART_TRIG = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.iSTART_TRIG = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    chk("pre_rst_busy", bus.oBUSY, 1);
    base = n_valid;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.oBUSY, 0);
    chk("mid_rst_cx", bus.oCX, 0);
    chk("mid_rst_cy", bus.oCY, 0);
    chk("mid_rst_nt", bus.oNO_TARGET, 0);
    chk("mid_rst_state", bus.oSTATE, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("no_valid_after_rst", n_valid, base);
    chk("busy_after_rst", bus.oBUSY, 0);

    run_op(20'd9, 28'd100, 28'd200, 1);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/centroid_divider.md
CENTROID_DIVIDER -- requirements
Module: centroid_divider

Interface
REQ-001 Parameter SUM_S_WIDTH, default 20: width of the pixel-count sum input.
REQ-002 Parameter SUM_SXY_WIDTH, default 28: width of each moment-sum input.
REQ-003 Parameter FRAC_BITS, default 4: fractional bits of each coordinate result.
REQ-004 Parameter COORD_WIDTH, default 10: integer bits of each coordinate result.
REQ-005 CCLK  input  1  clock; all state changes on the rising edge.
REQ-006 RST_N  input  1  reset, asynchronous, active-low.
REQ-007 iSTART_TRIG  input  1  level from the gravity-sum stage; its falling edge means the sums are final.
REQ-008 iSUM_S  input  SUM_S_WIDTH  count of above-threshold pixels.
REQ-009 iSUM_SX  input  SUM_SXY_WIDTH  sum of x weighted by pixel.
REQ-010 iSUM_SY  input  SUM_SXY_WIDTH  sum of y weighted by pixel.
REQ-011 oBUSY  output  1  high while a division is in progress; feeds the upstream iBUSY.
REQ-012 oCX  output  COORD_WIDTH+FRAC_BITS  centroid x, unsigned fixed point.
REQ-013 oCY  output  COORD_WIDTH+FRAC_BITS  centroid y, unsigned fixed point.
REQ-014 oVALID  output  1  one-cycle pulse when oCX, oCY and oNO_TARGET update.
REQ-015 oNO_TARGET  output  1  set when the last latched iSUM_S was 0.
REQ-016 oSTATE  output  2  debug copy of the state register.

Function
REQ-017 The block SHALL register iSTART_TRIG into trig_d every cycle; a start event SHALL be defined as trig_d=1 and iSTART_TRIG=0.
REQ-018 The states SHALL be IDLE=0, DIV_X=1, DIV_Y=2 and DONE=3.
REQ-019 In IDLE, on a start event at edge E0, the block SHALL latch all three sums and set oBUSY=1.
REQ-020 At E0, if the latched iSUM_S is nonzero, the block SHALL enter DIV_X; otherwise it SHALL enter DONE.
REQ-021 Start events in any state other than IDLE SHALL be ignored, and the latched sums SHALL hold.
REQ-022 Each axis SHALL divide the dividend {sum, FRAC_BITS zeros} (N = SUM_SXY_WIDTH+FRAC_BITS = 32 bits) by the latched iSUM_S.
REQ-023 Each division SHALL be an unsigned restoring division that produces one quotient bit per cycle, MSB first, over exactly N cycles.
REQ-024 The quotient SHALL be truncated, not rounded.
REQ-025 DIV_X SHALL run during edges E1..E32 and enter DIV_Y at E32.
REQ-026 DIV_Y SHALL run during edges E33..E64 and enter DONE at E64.
REQ-027 At the edge that leaves DONE (E65, or E1 for a zero divisor), the block SHALL load oCX and oCY, set oVALID=1, set oBUSY=0 and enter IDLE.
REQ-028 At that same edge, oNO_TARGET SHALL be set to (latched sum_s==0).
REQ-029 A quotient that exceeds 2^(COORD_WIDTH+FRAC_BITS)-1 SHALL saturate to all ones (0x3FFF by default).
REQ-030 For a zero divisor, oCX and oCY SHALL be 0, and oBUSY SHALL be high for exactly one cycle.
REQ-031 For a nonzero divisor, oBUSY SHALL be high for exactly 65 cycles.
REQ-032 oVALID SHALL be low in every cycle except the one following the DONE exit edge.
REQ-033 oCX, oCY and oNO_TARGET SHALL hold their values between oVALID pulses.
REQ-034 A start event coincident with the DONE exit edge SHALL be ignored.
REQ-035 The falling-edge start guarantees that oBUSY rises while upstream is in its post-trigger wait, so the upstream rise/fall busy detection sees both edges.
REQ-036 A start event SHALL begin a new division only from IDLE, including one arriving on the edge directly after a DONE exit.

Reset
REQ-037 While RST_N=0, the block SHALL force state=IDLE, trig_d=0, oBUSY=0, oVALID=0, oCX=0, oCY=0, oNO_TARGET=0, and clear the latched sums, remainder, quotient and iteration counter.
REQ-038 A reset asserted mid-division SHALL abort the division without an oVALID pulse.
REQ-039 After reset release, iSTART_TRIG held low SHALL cause no start event.
REQ-040 After reset release, a start event SHALL require iSTART_TRIG to be 1 for at least one cycle and then fall.

Verification
REQ-041 Nominal: S=100, SX=32000, SY=24050, trigger high 512 cycles then low -> oBUSY high 65 cycles, then one oVALID pulse with oCX=0x1400 (320.0) and oCY=0x0F08 (240.5).
REQ-042 Truncation: S=3, SX=10, SY=0 -> oCX=53 (0x035), oCY=0, oNO_TARGET=0.
REQ-043 Saturation: S=1, SX=2000, SY=5 -> oCX=0x3FFF, oCY=0x0050.
REQ-044 Zero divisor: S=0, any SX/SY -> oBUSY high 1 cycle, then oVALID with oCX=oCY=0 and oNO_TARGET=1.
REQ-045 Retrigger: second trigger fall during DIV_Y with different sums -> first result unchanged and exactly one oVALID pulse; then a later fall in IDLE produces the second result.
REQ-046 Reset mid-op: RST_N low at cycle 20 of DIV_X -> all outputs 0 immediately; no oVALID pulse follows.
